amm2apb_multi: RTL and testbench

AMM2APB_MULTI -- requirements
Module: amm2apb_multi

---
 rtl/amm2apb_pkg.sv | 23 ++
 rtl/amm2apb_timer.sv | 41 ++++
 rtl/amm2apb_multi.sv | 195 +++++++++++++++++++
 tb/tb_amm2apb_multi.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amm2apb_pkg.sv
// Shared response codes, FSM encoding and sizing helper for the Avalon-MM to APB bridge.
package amm2apb_pkg;

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;
    localparam logic [1:0] RESP_DECODEERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Ceiling log2 that never returns less than 1, so index fields always have a bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/amm2apb_timer.sv
// ACCESS-phase watchdog: counts cycles while enabled and flags the last allowed cycle.
module amm2apb_timer
    import amm2apb_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int               CNT_W  = clog2(TIMEOUT + 1);
    localparam int               LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(LAST_I);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is the TIMEOUT-th enabled cycle itself, so a same-cycle PREADY can still win.
    assign expired = (TIMEOUT > 0) && en && (count_q == LAST);

endmodule

// File: rtl/amm2apb_multi.sv
// Avalon-MM slave to multi-completer APB requester with address decode, timeout and error count.
module amm2apb_multi
    import amm2apb_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NSLV    = 4,
    parameter  int SEL_LSB = 12,
    parameter  int TIMEOUT = 256,
    localparam int SEL_W   = clog2(NSLV),
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            amm_address,
    input  logic [DATA_W-1:0]      amm_writedata,
    input  logic [STRB_W-1:0]      amm_byteenable,
    input  logic                   amm_write,
    input  logic                   amm_read,
    output logic [DATA_W-1:0]      amm_readdata,
    output logic [1:0]             amm_response,
    output logic                   amm_waitrequest,
    output logic [NSLV-1:0]        APB_PSEL,
    output logic                   APB_PENABLE,
    output logic                   APB_PWRITE,
    output logic [31:0]            APB_PADDR,
    output logic [DATA_W-1:0]      APB_PWDATA,
    output logic [STRB_W-1:0]      APB_PSTRB,
    input  logic [NSLV*DATA_W-1:0] APB_PRDATA,
    input  logic [NSLV-1:0]        APB_PREADY,
    input  logic [NSLV-1:0]        APB_PSLVERR,
    output logic [15:0]            err_count
);

    state_t              state_q,   state_d;
    logic [SEL_W-1:0]    idx_q,     idx_d;
    logic [NSLV-1:0]     psel_q,    psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q,  pwrite_d;
    logic [31:0]         paddr_q,   paddr_d;
    logic [DATA_W-1:0]   pwdata_q,  pwdata_d;
    logic [STRB_W-1:0]   pstrb_q,   pstrb_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic [1:0]          resp_q,    resp_d;
    logic                waitreq_q, waitreq_d;
    logic [15:0]         err_q,     err_d;

    logic [SEL_W-1:0]    req_idx;
    logic [NSLV-1:0]     req_sel;
    logic                sel_ready;
    logic                sel_slverr;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timer_clr;
    logic                timer_en;
    logic                timer_expired;

    assign req_idx = amm_address[SEL_LSB +: SEL_W];

    // Decode the incoming index and mux the captured completer's response lines.
    always_comb begin
        req_sel    = '0;
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NSLV; i++) begin
            req_sel[i] = (req_idx == SEL_W'(i));
            if (idx_q == SEL_W'(i)) begin
                sel_ready  = APB_PREADY[i];
                sel_slverr = APB_PSLVERR[i];
                sel_rdata  = APB_PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timer_clr = (state_q == ST_SETUP);
    assign timer_en  = (state_q == ST_ACCESS);

    amm2apb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (amm_read || amm_write) begin
                    idx_d    = req_idx;
                    paddr_d  = amm_address;
                    pwdata_d = amm_writedata;
                    pwrite_d = amm_write;
                    pstrb_d  = amm_write ? amm_byteenable : '0;
                    if (|req_sel) begin
                        psel_d    = req_sel;
                        penable_d = 1'b0;
                        state_d   = ST_SETUP;
                    end else begin
                        rdata_d = '0;
                        resp_d  = RESP_DECODEERR;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    rdata_d   = pwrite_q ? '0 : sel_rdata;
                    resp_d    = sel_slverr ? RESP_SLVERR : RESP_OKAY;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (timer_expired) begin
                    rdata_d   = '0;
                    resp_d    = RESP_SLVERR;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // DONE is only ever entered from another state, so this counts each response once.
        if ((state_d == ST_DONE) && (resp_d != RESP_OKAY) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end

        waitreq_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            waitreq_q <= 1'b1;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            waitreq_q <= waitreq_d;
            err_q     <= err_d;
        end
    end

    assign APB_PSEL        = psel_q;
    assign APB_PENABLE     = penable_q;
    assign APB_PWRITE      = pwrite_q;
    assign APB_PADDR       = paddr_q;
    assign APB_PWDATA      = pwdata_q;
    assign APB_PSTRB       = pstrb_q;
    assign amm_readdata    = rdata_q;
    assign amm_response    = resp_q;
    assign amm_waitrequest = waitreq_q;
    assign err_count       = err_q;

endmodule

// File: tb/tb_amm2apb_multi.sv
// Scoreboard bench for amm2apb_multi with three completers and a 16-cycle timeout.
module tb_amm2apb_multi;

    localparam int DATA_W  = 32;
    localparam int NSLV    = 3;
    localparam int SEL_LSB = 12;
    localparam int TIMEOUT = 16;
    localparam int STRB_W  = DATA_W / 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [31:0]            amm_address;
    logic [DATA_W-1:0]      amm_writedata;
    logic [STRB_W-1:0]      amm_byteenable;
    logic                   amm_write;
    logic                   amm_read;
    logic [DATA_W-1:0]      amm_readdata;
    logic [1:0]             amm_response;
    logic                   amm_waitrequest;
    logic [NSLV-1:0]        APB_PSEL;
    logic                   APB_PENABLE;
    logic                   APB_PWRITE;
    logic [31:0]            APB_PADDR;
    logic [DATA_W-1:0]      APB_PWDATA;
    logic [STRB_W-1:0]      APB_PSTRB;
    logic [NSLV*DATA_W-1:0] APB_PRDATA;
    logic [NSLV-1:0]        APB_PREADY;
    logic [NSLV-1:0]        APB_PSLVERR;
    logic [15:0]            err_count;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          idx;
        int          issue;
        int          lat;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [15:0] errc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cycle_cnt = 0;
    int          cfg_wait  = 0;
    int          acc_cnt   = 0;
    logic [15:0] model_err = 16'd0;

    amm2apb_multi #(
        .DATA_W  (DATA_W),
        .NSLV    (NSLV),
        .SEL_LSB (SEL_LSB),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .amm_address     (amm_address),
        .amm_writedata   (amm_writedata),
        .amm_byteenable  (amm_byteenable),
        .amm_write       (amm_write),
        .amm_read        (amm_read),
        .amm_readdata    (amm_readdata),
        .amm_response    (amm_response),
        .amm_waitrequest (amm_waitrequest),
        .APB_PSEL        (APB_PSEL),
        .APB_PENABLE     (APB_PENABLE),
        .APB_PWRITE      (APB_PWRITE),
        .APB_PADDR       (APB_PADDR),
        .APB_PWDATA      (APB_PWDATA),
        .APB_PSTRB       (APB_PSTRB),
        .APB_PRDATA      (APB_PRDATA),
        .APB_PREADY      (APB_PREADY),
        .APB_PSLVERR     (APB_PSLVERR),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference behaviour: decode, then wait-or-timeout outcome from the chosen completer.
    function automatic exp_t model(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                   input logic [3:0] be, input int wait_cyc,
                                   input logic [95:0] prdata, input logic [2:0] slverr);
        exp_t e;
        int   idx;
        idx     = int'((addr >> SEL_LSB) & 32'h3);
        e.addr  = addr;
        e.write = wr;
        e.wdata = wdata;
        e.strb  = wr ? be : 4'h0;
        e.rdata = 32'h0;
        e.resp  = 2'b00;
        e.issue = 0;
        e.errc  = 16'h0;
        if (idx >= NSLV) begin
            e.idx  = -1;
            e.lat  = 1;
            e.resp = 2'b11;
        end else begin
            e.idx = idx;
            if (wait_cyc < TIMEOUT) begin
                e.lat  = 3 + wait_cyc;
                e.resp = slverr[idx] ? 2'b10 : 2'b00;
                if (!wr) e.rdata = prdata[idx*32 +: 32];
            end else begin
                e.lat  = 2 + TIMEOUT;
                e.resp = 2'b10;
            end
        end
        return e;
    endfunction

    task automatic issue_request(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [31:0] wdata, input logic [3:0] be, input int wait_cyc,
                                 input logic [95:0] prdata, input logic [2:0] slverr);
        exp_t e;
        APB_PRDATA     = prdata;
        APB_PSLVERR    = slverr;
        cfg_wait       = wait_cyc;
        amm_address    = addr;
        amm_writedata  = wdata;
        amm_byteenable = be;
        amm_read       = rd;
        amm_write      = wr;
        e = model(addr, wr, wdata, be, wait_cyc, prdata, slverr);
        if (e.resp != 2'b00 && model_err != 16'hFFFF) model_err++;
        e.errc  = model_err;
        e.issue = cycle_cnt;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                  input logic [31:0] wdata, input logic [3:0] be, input int wait_cyc,
                                  input logic [95:0] prdata, input logic [2:0] slverr);
        int n;
        issue_request(addr, rd, wr, wdata, be, wait_cyc, prdata, slverr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (amm_waitrequest && n < 100);
        if (amm_waitrequest) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no DONE after %0d cycles, expected one", n);
        end
        @(negedge clk);
        amm_read  = 1'b0;
        amm_write = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_psel"},    APB_PSEL,        64'h0);
        check_output({tag, "_penable"}, APB_PENABLE,     64'h0);
        check_output({tag, "_paddr"},   APB_PADDR,       64'h0);
        check_output({tag, "_pwdata"},  APB_PWDATA,      64'h0);
        check_output({tag, "_pwrite"},  APB_PWRITE,      64'h0);
        check_output({tag, "_pstrb"},   APB_PSTRB,       64'h0);
        check_output({tag, "_waitreq"}, amm_waitrequest, 64'h1);
        check_output({tag, "_rdata"},   amm_readdata,    64'h0);
        check_output({tag, "_resp"},    amm_response,    64'h0);
        check_output({tag, "_errcnt"},  err_count,       64'h0);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        amm_read  = 1'b0;
        amm_write = 1'b0;
        exp_q.delete();
        model_err = 16'd0;
        #1;
        check_reset_values(tag);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Completer models: the selected one raises PREADY after cfg_wait ACCESS cycles, others toggle randomly.
    initial begin : responder
        APB_PREADY = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NSLV; i++) begin
                if (APB_PSEL[i] && APB_PENABLE) begin
                    APB_PREADY[i] = (acc_cnt == cfg_wait);
                    acc_cnt++;
                end else begin
                    APB_PREADY[i] = 1'($urandom_range(0, 1));
                end
            end
            if (!APB_PENABLE) acc_cnt = 0;
        end
    end

    // Monitor: checks APB phases against the head transaction and pops it on every DONE.
    initial begin : monitor
        exp_t        e;
        logic        prev_sel;
        logic        after_done;
        logic [1:0]  last_resp;
        logic [31:0] last_rdata;
        prev_sel   = 1'b0;
        after_done = 1'b0;
        last_resp  = 2'b00;
        last_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_sel   = 1'b0;
                after_done = 1'b0;
            end else begin
                if (after_done) begin
                    check_output("waitreq_single", amm_waitrequest, 64'h1);
                    check_output("resp_hold",      amm_response,    last_resp);
                    check_output("rdata_hold",     amm_readdata,    last_rdata);
                    after_done = 1'b0;
                end
                if (APB_PSEL != '0 || APB_PENABLE) begin
                    if (exp_q.size() == 0) begin
                        check_output("apb_unexpected", APB_PSEL, 64'h0);
                    end else begin
                        e = exp_q[0];
                        if (e.idx < 0) begin
                            check_output("psel_decerr", APB_PSEL, 64'h0);
                        end else begin
                            check_output("psel",    APB_PSEL,    64'h1 << e.idx);
                            check_output("penable", APB_PENABLE, prev_sel);
                            check_output("paddr",   APB_PADDR,   e.addr);
                            check_output("pwrite",  APB_PWRITE,  e.write);
                            check_output("pstrb",   APB_PSTRB,   e.strb);
                            if (e.write) check_output("pwdata", APB_PWDATA, e.wdata);
                        end
                    end
                    prev_sel = 1'b1;
                end else begin
                    prev_sel = 1'b0;
                end
                if (!amm_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_done", amm_waitrequest, 64'h1);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("readdata",     amm_readdata,        e.rdata);
                        check_output("response",     amm_response,        e.resp);
                        check_output("err_count",    err_count,           e.errc);
                        check_output("latency",      cycle_cnt - e.issue, e.lat);
                        check_output("done_psel",    APB_PSEL,            64'h0);
                        check_output("done_penable", APB_PENABLE,         64'h0);
                        last_resp  = e.resp;
                        last_rdata = e.rdata;
                        after_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: got no finish by 300000 ns, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases first, then a randomised mix of reads, writes, decode errors and timeouts.
    initial begin : stimulus
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [95:0] pd;
        logic [2:0]  se;
        int          kind;
        int          w;
        int          r;
        int          gap;

        reset          = 1'b0;
        amm_address    = '0;
        amm_writedata  = '0;
        amm_byteenable = '0;
        amm_read       = 1'b0;
        amm_write      = 1'b0;
        APB_PRDATA     = '0;
        APB_PSLVERR    = '0;
        #1;
        do_reset("por");

        apply_stimulus(32'h0000_2004, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 0,
                       {$urandom, $urandom, $urandom}, 3'b000);
        apply_stimulus(32'h0000_1000, 1'b1, 1'b0, 32'h0, 4'hF, 5,
                       {32'hAAAA_0002, 32'h1234_5678, 32'h5555_0000}, 3'b000);
        apply_stimulus(32'h0000_3000, 1'b1, 1'b0, 32'h0, 4'hF, 0,
                       {$urandom, $urandom, $urandom}, 3'b000);
        apply_stimulus(32'h0000_0040, 1'b1, 1'b0, 32'h0, 4'hF, 1000,
                       {$urandom, $urandom, $urandom}, 3'b000);
        apply_stimulus(32'h0000_0040, 1'b1, 1'b0, 32'h0, 4'hF, TIMEOUT - 1,
                       {32'h0, 32'h0, 32'hC0DE_0016}, 3'b000);

        do_reset("pre");
        apply_stimulus(32'h0000_0010, 1'b0, 1'b1, 32'h0BAD_F00D, 4'h3, 0,
                       {$urandom, $urandom, $urandom}, 3'b001);
        issue_request(32'h0000_1008, 1'b1, 1'b0, 32'h0, 4'hF, 0,
                      {$urandom, $urandom, $urandom}, 3'b000);
        @(negedge clk);
        #2;
        do_reset("mid");
        apply_stimulus(32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'hF, 2,
                       {32'h7777_8888, 32'h0, 32'h0}, 3'b000);

        for (int t = 0; t < 60; t++) begin
            a        = $urandom;
            a[13:12] = 2'($urandom_range(0, 3));
            wd       = $urandom;
            be       = 4'($urandom);
            pd       = {$urandom, $urandom, $urandom};
            se       = 3'($urandom);
            kind     = $urandom_range(0, 2);
            r        = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 4);
            else if (r == 7) w = $urandom_range(13, 15);
            else             w = $urandom_range(16, 40);
            apply_stimulus(a, (kind != 1), (kind != 0), wd, be, w, pd, se);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check_output("queue_drain", exp_q.size(), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
